mux_scan_sequencer: RTL and testbench

Round-robin channel scanner that drives the select lines of the 4:1 decoder/tri-state multiplexer and captures its output. It walks the four input channels whose request bit is set, waits a programmable settle time after each select change, samples the mux output and presents it downstream with its channel tag over a valid/ready handshake. It sits directly around the mux: select lines out to it, mux `Y` back in.

---
 rtl/mux_scan_sequencer.sv | 124 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Round-robin scanner around a 4:1 mux: drives the selects, waits a settle
// time, samples Y and hands it downstream with its channel tag.
module mux_scan_sequencer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic       S0,
    output logic       S1,
    input  logic       y_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic [1:0] out_ch,
    output logic       busy
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [1:0] sel;
    logic [1:0] last;
    logic [1:0] grant;
    logic       any_req;
    logic       load_sel;
    logic       take_sample;
    logic       out_clr;

    assign any_req = |req;

    // First requesting channel strictly after last-served, wrapping.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        load_sel    = 1'b0;
        take_sample = 1'b0;
        out_clr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && any_req) begin
                    state_n  = SETTLE;
                    load_sel = 1'b1;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n     = HOLD;
                    take_sample = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_clr = 1'b1;
                    if (en && any_req) begin
                        state_n  = SETTLE;
                        load_sel = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            sel       <= 2'd0;
            last      <= 2'd3;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_ch    <= 2'd0;
        end else begin
            state <= state_n;
            if (load_sel) begin
                sel <= grant;
                cnt <= 4'd0;
            end else if (state == SETTLE) begin
                cnt <= cnt + 4'd1;
            end
            if (take_sample) begin
                out_data  <= y_in;
                out_ch    <= sel;
                out_valid <= 1'b1;
                last      <= sel;
            end else if (out_clr) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign S0   = sel[0];
    assign S1   = sel[1];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mux_scan_sequencer;

    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       S0;
    logic       S1;
    logic       y_in;
    logic       out_valid;
    logic       out_ready;
    logic       out_data;
    logic [1:0] out_ch;
    logic       busy;
    logic [3:0] mux_i;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    bit       m_idle;
    bit       m_hold;
    int       m_left;
    int       m_sel;
    int       m_last;
    bit       m_valid;
    bit       m_data;
    int       m_ch;

    typedef struct {
        bit       en;
        bit [3:0] req;
        bit       rdy;
        bit       valid;
        bit [1:0] ch;
        bit       data;
        bit [1:0] sel;
        bit       busy;
    } vec_t;

    vec_t vt[15];

    mux_scan_sequencer #(.SETTLE_CYC(SC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .S0       (S0),
        .S1       (S1),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign y_in = mux_i[{S1, S0}];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int next_ch(input int last, input bit [3:0] r);
        for (int d = 1; d <= 4; d++) begin
            if (r[(last + d) % 4]) return (last + d) % 4;
        end
        return last;
    endfunction

    task automatic model_reset();
        m_idle  = 1; m_hold = 0; m_left = 0;
        m_sel   = 0; m_last = 3;
        m_valid = 0; m_data = 0; m_ch = 0;
    endtask

    task automatic model_step();
        if (m_idle) begin
            if (en && req != 0) begin
                m_sel  = next_ch(m_last, req);
                m_left = SC;
                m_idle = 0;
            end
        end else if (m_hold) begin
            if (out_ready) begin
                m_valid = 0;
                m_hold  = 0;
                if (en && req != 0) begin
                    m_sel  = next_ch(m_last, req);
                    m_left = SC;
                end else begin
                    m_idle = 1;
                end
            end
        end else if (!en) begin
            m_idle = 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_data  = mux_i[m_sel];
                m_ch    = m_sel;
                m_valid = 1;
                m_last  = m_sel;
                m_hold  = 1;
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        check({tag, ".valid"}, int'(out_valid), int'(m_valid));
        check({tag, ".data"}, int'(out_data), int'(m_data));
        check({tag, ".ch"}, int'(out_ch), m_ch);
        check({tag, ".sel"}, int'({S1, S0}), m_sel);
        check({tag, ".busy"}, int'(busy), int'(!m_idle));
    endtask

    task automatic step(input bit e, input bit [3:0] r, input bit rdy,
                        input string tag);
        en        = e;
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 0; req = 0; out_ready = 0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit [1:0] snap_ch;
        bit       snap_d;
        int       prev_ch;
        bit       seen;

        rst_n = 1'b0;
        en = 0; req = 0; out_ready = 0;
        mux_i = 4'b1010;
        model_reset();
        #2;
        check("rst.valid", int'(out_valid), 0);
        check("rst.sel", int'({S1, S0}), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.ch", int'(out_ch), 0);
        check("rst.data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full scan, out_ready held high, I=1010
        vt[0]  = '{1, 4'hF, 1, 0, 0, 0, 0, 1};
        vt[1]  = '{1, 4'hF, 1, 0, 0, 0, 0, 1};
        vt[2]  = '{1, 4'hF, 1, 1, 0, 0, 0, 1};
        vt[3]  = '{1, 4'hF, 1, 0, 0, 0, 1, 1};
        vt[4]  = '{1, 4'hF, 1, 0, 0, 0, 1, 1};
        vt[5]  = '{1, 4'hF, 1, 1, 1, 1, 1, 1};
        vt[6]  = '{1, 4'hF, 1, 0, 1, 1, 2, 1};
        vt[7]  = '{1, 4'hF, 1, 0, 1, 1, 2, 1};
        vt[8]  = '{1, 4'hF, 1, 1, 2, 0, 2, 1};
        vt[9]  = '{1, 4'hF, 1, 0, 2, 0, 3, 1};
        vt[10] = '{1, 4'hF, 1, 0, 2, 0, 3, 1};
        vt[11] = '{1, 4'hF, 1, 1, 3, 1, 3, 1};
        vt[12] = '{1, 4'hF, 1, 0, 3, 1, 0, 1};
        vt[13] = '{1, 4'hF, 1, 0, 3, 1, 0, 1};
        vt[14] = '{1, 4'hF, 1, 1, 0, 0, 0, 1};
        for (int i = 0; i < 15; i++) begin
            step(vt[i].en, vt[i].req, vt[i].rdy, $sformatf("vec%0d", i));
            check($sformatf("tv%0d.valid", i), int'(out_valid), int'(vt[i].valid));
            check($sformatf("tv%0d.ch", i), int'(out_ch), int'(vt[i].ch));
            check($sformatf("tv%0d.data", i), int'(out_data), int'(vt[i].data));
            check($sformatf("tv%0d.sel", i), int'({S1, S0}), int'(vt[i].sel));
            check($sformatf("tv%0d.busy", i), int'(busy), int'(vt[i].busy));
        end

        // Only channels 0 and 2, alternating
        do_reset();
        prev_ch = -1;
        for (int i = 0; i < 12; i++) begin
            step(1, 4'b0101, 1, "alt");
            check("alt.sel_even", int'(S0), 0);
            if (out_valid) begin
                if (prev_ch >= 0)
                    check("alt.ch", int'(out_ch), (prev_ch + 2) % 4);
                prev_ch = out_ch;
            end
        end

        // Backpressure: sample held, select frozen
        do_reset();
        step(1, 4'hF, 1, "bp");
        step(1, 4'hF, 1, "bp");
        step(1, 4'hF, 1, "bp");
        check("bp.first_valid", int'(out_valid), 1);
        snap_ch = out_ch;
        snap_d  = out_data;
        for (int i = 0; i < 5; i++) begin
            step(1, 4'hF, 0, "bp_hold");
            check("bp.valid_held", int'(out_valid), 1);
            check("bp.ch_held", int'(out_ch), int'(snap_ch));
            check("bp.data_held", int'(out_data), int'(snap_d));
            check("bp.sel_held", int'({S1, S0}), 0);
        end
        step(1, 4'hF, 1, "bp_rel");
        check("bp.sel_adv", int'({S1, S0}), 1);
        check("bp.valid_clr", int'(out_valid), 0);

        // en dropped during SETTLE, then resume after last-served
        do_reset();
        step(1, 4'hF, 1, "en");
        step(1, 4'hF, 1, "en");
        step(1, 4'hF, 1, "en");
        step(1, 4'hF, 1, "en");
        check("en.sel1", int'({S1, S0}), 1);
        step(0, 4'hF, 1, "en_drop");
        check("en.busy0", int'(busy), 0);
        check("en.novalid", int'(out_valid), 0);
        step(0, 4'hF, 1, "en_idle");
        step(1, 4'hF, 1, "en_resume");
        check("en.resume_sel", int'({S1, S0}), 1);
        step(1, 4'hF, 1, "en_resume");
        step(1, 4'hF, 1, "en_resume");
        check("en.resume_ch", int'(out_ch), 1);

        // Async reset while holding a sample from channel 2
        do_reset();
        step(1, 4'b0100, 0, "ar");
        step(1, 4'b0100, 0, "ar");
        step(1, 4'b0100, 0, "ar");
        check("ar.hold_valid", int'(out_valid), 1);
        check("ar.hold_sel", int'({S1, S0}), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid0", int'(out_valid), 0);
        check("ar.sel0", int'({S1, S0}), 0);
        check("ar.busy0", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 4'b1000, 1, "ar_rel");
            if (out_valid) begin
                seen = 1;
                check("ar.first_ch", int'(out_ch), 3);
            end
        end
        if (!seen) check("ar.timeout", 0, 1);

        // Request withdrawn mid-settle still delivers
        do_reset();
        step(1, 4'b0010, 0, "rd");
        step(1, 4'b0000, 0, "rd");
        step(1, 4'b0000, 0, "rd");
        check("rd.valid", int'(out_valid), 1);
        check("rd.ch", int'(out_ch), 1);
        check("rd.data", int'(out_data), int'(mux_i[1]));
        step(1, 4'b0000, 1, "rd_ack");
        check("rd.idle", int'(busy), 0);

        // out_ready while idle is ignored
        step(0, 4'b0000, 1, "idle_rdy");
        check("idle.valid", int'(out_valid), 0);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mux_i = 4'($urandom);
            step($urandom_range(0, 7) != 0, 4'($urandom),
                 1'($urandom_range(0, 1)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
